// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared sizes, state encoding and one-hot helper for the round-robin mux arbiter
package rr_arb_pkg;
  localparam int N_REQ = 16;
  localparam int SEL_W = 4;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  function automatic logic [0:N_REQ-1] onehot(input logic [SEL_W-1:0] i);
    onehot = '0;
    onehot[i] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: circular priority search over 16 requests starting at ptr
module rr_pick16
  import rr_arb_pkg::*;
(
  input  logic [0:N_REQ-1] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [N_REQ-1:0] r;
  logic [2*N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    for (int i = 0; i < N_REQ; i++) r[i] = req[i];
    rot = {r, r} >> ptr;
    off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) if (rot[j]) off = SEL_W'(j);
    any = |r;
    idx = ptr + off;
  end
endmodule

// File: rtl/rr_mux16_arbiter.sv
// rr_mux16_arbiter: round-robin grant sequencer sharing one 16:1 mux, with hold timeout
module rr_mux16_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [0:N_REQ-1] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [0:N_REQ-1] grant,
  output logic             valid,
  output logic             timed_out
);
  localparam int HW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
  logic st, st_n, any, gnt, rel, norm, tmo;
  logic [SEL_W-1:0] ptr, idx;
  logic [HW-1:0] hold_cnt;
  rr_pick16 u_pick (.req(req), .ptr(ptr), .any(any), .idx(idx));
  always_comb begin
    norm = done || !req[sel];
    tmo = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1));
    rel = (st == ST_BUSY) && (norm || tmo);
    gnt = (st == ST_IDLE) && enable && any;
    st_n = gnt ? ST_BUSY : rel ? ST_IDLE : st;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_IDLE;
      sel <= '0;
      grant <= '0;
      valid <= 1'b0;
      timed_out <= 1'b0;
      ptr <= '0;
      hold_cnt <= '0;
    end else begin
      st <= st_n;
      timed_out <= rel && !norm;
      if (gnt) begin
        sel <= idx;
        grant <= onehot(idx);
        valid <= 1'b1;
        hold_cnt <= '0;
      end else if (rel) begin
        grant <= '0;
        valid <= 1'b0;
        ptr <= sel + 1'b1;
      end else if (st == ST_BUSY) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule
